regfile: RTL and testbench

General-purpose register file serving the decode stage's two register read requests and the write-back stage's single write. It holds 32 × 32-bit registers with `$0` hardwired to zero and same-cycle write-to-read bypass. After every reset, a sequencer clears all registers to zero and asserts `busy_o` so the pipeline can stall until the array is defined. Decode-stage forwarding from EX/MEM sits in front of this block; this block only resolves the write-back-stage hazard.

---
 rtl/regfile.sv | 45 ++++
 tb/tb_regfile.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32x32 register file, $0 hardwired to zero, write-back bypass, post-reset clear sequencer.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy_o
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem [1:NREG-1];
  logic              w_wr;
  assign busy_o = (r_state == CLEAR);
  assign w_wr   = we && (waddr != '0);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= ADDR_W'(1);
    end else if (r_state == CLEAR) begin
      r_mem[r_ptr] <= '0;
      if (r_ptr == ADDR_W'(NREG-1)) r_state <= READY;
      else r_ptr <= r_ptr + ADDR_W'(1);
    end else if (w_wr) begin
      r_mem[waddr] <= wdata;
    end
  // Zero gating outranks bypass so $0, reset and the clear window never leak wdata.
  always_comb begin
    rdata1 = (rst || !re1 || raddr1 == '0 || busy_o) ? '0 :
             (we && waddr == raddr1) ? wdata : r_mem[raddr1];
    rdata2 = (rst || !re2 || raddr2 == '0 || busy_o) ? '0 :
             (we && waddr == raddr2) ? wdata : r_mem[raddr2];
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed checks of reset clear, write/read-back, bypass, $0 and reset restarts.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst, we, re1, re2;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic        busy_o;
  int          total = 0;
  int          bad = 0;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_run(input string tag);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk(tag, {31'd0, busy_o}, {31'd0, i < 31});
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    tick();
    chk("reset_busy", {31'd0, busy_o}, 32'd1);
    re1 = 1'b1; raddr1 = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0001;
    #1;
    chk("read_in_rst", rdata1, 32'h0);
    tick();
    we = 1'b0; rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      if (i == 3) begin
        we = 1'b1; waddr = 5'd20; wdata = 32'h55; raddr1 = 5'd20;
        #1;
        chk("bypass_while_busy", rdata1, 32'h0);
      end
      tick();
      if (i == 3) we = 1'b0;
      chk("clear_busy", {31'd0, busy_o}, {31'd0, i < 31});
    end
    re2 = 1'b1;
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      #1;
      chk("cleared_p1", rdata1, 32'h0);
      chk("cleared_p2", rdata2, 32'h0);
    end
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    chk("r5_p1", rdata1, 32'hDEADBEEF);
    chk("r5_p2", rdata2, 32'hDEADBEEF);
    raddr1 = 5'd6;
    #1;
    chk("r6_zero", rdata1, 32'h0);
    we = 1'b1; waddr = 5'd7; wdata = 32'hAAAA0000;
    tick();
    we = 1'b0; re2 = 1'b0; raddr2 = 5'd7;
    #1;
    chk("re2_off", rdata2, 32'h0);
    re2 = 1'b1;
    #1;
    chk("r7_old", rdata2, 32'hAAAA0000);
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr1 = 5'd7; re1 = 1'b1;
    #1;
    chk("bypass_p1", rdata1, 32'h12345678);
    chk("bypass_p2", rdata2, 32'h12345678);
    tick();
    we = 1'b0;
    #1;
    chk("r7_mem", rdata1, 32'h12345678);
    raddr1 = 5'd5;
    #1;
    chk("r5_kept", rdata1, 32'hDEADBEEF);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("r0_bypass_p1", rdata1, 32'h0);
    chk("r0_bypass_p2", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("r0_p1", rdata1, 32'h0);
    chk("r0_p2", rdata2, 32'h0);
    raddr1 = 5'd20;
    #1;
    chk("r20_busy_write_dropped", rdata1, 32'h0);
    we = 1'b1; waddr = 5'd1; wdata = 32'h9;
    tick();
    we = 1'b0; raddr1 = 5'd1;
    #1;
    chk("r1_written", rdata1, 32'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("busy_after_ready_rst", {31'd0, busy_o}, 32'd1);
    for (int i = 1; i <= 10; i++) tick();
    chk("busy_mid_clear", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_run("restart_busy");
    #1;
    chk("r1_cleared", rdata1, 32'h0);
    raddr2 = 5'd7;
    #1;
    chk("r7_cleared", rdata2, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
